// File: rtl/iic_video_cfg.sv
// iic_video_cfg
//
// Power-up register loader for the video-path I2C peripherals (DVI transmitter,
// VGA digitizer). It walks an external register table and issues one 3-byte
// write per entry: {DEV_ADDR, W}, reg, data. NACKed entries are retried
// RETRIES more times. The sequence then reports done, or reports error with
// the failing entry in err_idx.
//
// Bus timing: a prescaler produces a quarter tick every DIV clocks. Every bus
// phase (START, one data/ACK bit, STOP, GAP) lasts four quarters, Q0..Q3. A
// slave holding SCL low while the master releases it in Q1 of a bit freezes
// the prescaler, which gives clock stretching.
//
// Ports:
//   clk, rst_n        system clock; asynchronous active-low reset
//   start             one-cycle launch pulse; ignored while busy
//   tbl_idx/tbl_data  table address out; {reg, data} back (comb or 1-cycle ROM)
//   scl_i/sda_i       pad inputs (stretch detect / ACK sample)
//   scl_oe/sda_oe     1 = pull line low, 0 = release (open drain at top level)
//   busy              sequence in progress
//   done/error        status levels, held until the next launch
//   err_idx           entry that exhausted its retries

module iic_video_cfg #(
  parameter int unsigned DIV        = 100,
  parameter int unsigned NUM_REGS   = 16,
  parameter logic [6:0]  DEV_ADDR   = 7'h76,
  parameter int unsigned RETRIES    = 2,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  tbl_idx,
  input  logic [15:0] tbl_data,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_idx
);

  localparam int unsigned CntW   = $clog2(DIV);
  localparam int unsigned RetryW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  localparam logic [CntW-1:0]   CntMax   = CntW'(DIV - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(RETRIES);
  localparam logic [7:0]        LastIdx  = 8'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBit,
    StStop,
    StGap,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [4:0]        bit_q, bit_d;
  logic [26:0]       frame_q, frame_d;
  logic              nack_q, nack_d;
  logic              last_q, last_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        err_idx_q, err_idx_d;
  logic              auto_q, auto_d;
  logic              pend_q, pend_d;
  logic              scl_oe_q, scl_oe_d;
  logic              sda_oe_q, sda_oe_d;

  logic in_bus;
  logic stretch;
  logic qend;
  logic phase_end;
  logic ack_slot;

  assign in_bus    = (state_q == StStart) || (state_q == StBit) ||
                     (state_q == StStop)  || (state_q == StGap);
  // The slave keeps SCL low after we released it: freeze the quarter timer.
  assign stretch   = (state_q == StBit) && (qtr_q == 2'd1) && !scl_i;
  assign qend      = in_bus && !stretch && (cnt_q == CntMax);
  assign phase_end = qend && (qtr_q == 2'd3);
  // Bits 8, 17 and 26 of the 27-bit frame are the slave's ACK slots.
  assign ack_slot  = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    nack_d    = nack_q;
    last_d    = last_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    pend_d    = pend_q;
    auto_d    = 1'b0;
    scl_oe_d  = 1'b0;
    sda_oe_d  = 1'b0;

    // Quarter prescaler, running only while a bus phase is in progress.
    if (in_bus && !stretch) begin
      if (qend) begin
        cnt_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        pend_d = 1'b0;
        if (start || auto_q || pend_q) begin
          state_d = StStart;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          nack_d  = 1'b0;
          cnt_d   = '0;
          qtr_d   = '0;
        end
      end

      StStart: begin
        // Latched at the end of Q0 so a registered ROM has settled on tbl_idx.
        if (qend && (qtr_q == 2'd0)) begin
          frame_d = {DEV_ADDR, 1'b0, 1'b1, tbl_data[15:8], 1'b1, tbl_data[7:0], 1'b1};
          nack_d  = 1'b0;
        end
        if (phase_end) begin
          state_d = StBit;
          bit_d   = '0;
        end
      end

      StBit: begin
        if (qend && (qtr_q == 2'd1) && ack_slot && sda_i) begin
          nack_d = 1'b1;
        end
        if (phase_end) begin
          if (nack_q || (bit_q == 5'd26)) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 5'd1;
            frame_d = {frame_q[25:0], 1'b0};
          end
        end
      end

      StStop: begin
        if (phase_end) begin
          state_d = StGap;
          last_d  = (idx_q == LastIdx);
          // Advance the table during GAP so the next entry is stable long
          // before it is latched in the following START.
          if (!nack_q && (idx_q != LastIdx)) begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      StGap: begin
        if (phase_end) begin
          if (nack_q) begin
            if (retry_q < RetryMax) begin
              retry_d = retry_q + RetryW'(1);
              state_d = StStart;
            end else begin
              error_d   = 1'b1;
              err_idx_d = idx_q;
              state_d   = StFin;
            end
          end else if (last_q) begin
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            retry_d = '0;
            state_d = StStart;
          end
        end
      end

      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
        // A start coinciding with FIN is honoured one cycle later.
        if (start) begin
          pend_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Line drive is decoded from the next phase/quarter and registered, so
    // pad enables only move on quarter boundaries and are glitch free.
    unique case (state_d)
      StStart: begin
        scl_oe_d = (qtr_d == 2'd3);
        sda_oe_d = qtr_d[1];
      end
      StBit: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_oe_d = ~frame_d[26];
      end
      StStop: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = ~qtr_d[1];
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      nack_q    <= 1'b0;
      last_q    <= 1'b0;
      retry_q   <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      auto_q    <= AUTO_START;
      pend_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      nack_q    <= nack_d;
      last_q    <= last_d;
      retry_q   <= retry_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      auto_q    <= auto_d;
      pend_q    <= pend_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign tbl_idx = idx_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_iic_video_cfg.sv
// Bench for iic_video_cfg: an I2C bus decoder plus scripted slave (ACK/NACK per
// attempt, optional SCL stretch) records every write attempt; a table-driven
// reference model predicts the attempts, final status and sequence length.

module tb_iic_video_cfg;

  localparam int DIV  = 2;
  localparam int NREG = 2;
  localparam int RETR = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_data;
  logic        scl_i, sda_i, scl_oe, sda_oe;
  logic        busy, done, error;
  logic [7:0]  err_idx;

  iic_video_cfg #(
    .DIV       (DIV),
    .NUM_REGS  (NREG),
    .DEV_ADDR  (7'h76),
    .RETRIES   (RETR),
    .AUTO_START(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tbl_idx (tbl_idx),
    .tbl_data(tbl_data),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .err_idx (err_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] tbl [NREG];
  assign tbl_data = (int'(tbl_idx) < NREG) ? tbl[tbl_idx[0]] : 16'h0000;

  // Open-drain pads shared by master and slave model.
  logic slv_scl, slv_sda;
  assign scl_i = ~(scl_oe | slv_scl);
  assign sda_i = ~(sda_oe | slv_sda);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // plan[a]: byte number (0..2) the slave NACKs in attempt a, 3 = ACK all.
  int          plan [16];
  int          att;
  logic        prev_scl, prev_sda, prev_scl_oe;
  int          bitcnt;
  logic [7:0]  shreg;
  bit          in_frame, ack_pend, in_ack;
  logic [7:0]  cur_idx;
  int          cur_n;
  logic [23:0] cur_bytes;
  logic [39:0] obs_q [$];
  int          rel_cnt, hold_cnt;
  bit          str_arm;
  int          str_att, str_rel, str_len;

  always @(negedge clk) begin
    logic scl_l, sda_l;
    // Stretch: grab SCL right as the master releases it for the chosen bit.
    if (prev_scl_oe && !scl_oe) begin
      rel_cnt++;
      if (str_arm && att == str_att && rel_cnt == str_rel) begin
        slv_scl  = 1'b1;
        hold_cnt = str_len;
        str_arm  = 1'b0;
      end
    end else if (slv_scl) begin
      hold_cnt--;
      if (hold_cnt == 0) slv_scl = 1'b0;
    end
    prev_scl_oe = scl_oe;
    scl_l = !(scl_oe || slv_scl);
    sda_l = !(sda_oe || slv_sda);
    if (prev_scl && scl_l && prev_sda && !sda_l) begin
      att++;
      rel_cnt   = 0;
      bitcnt    = 0;
      in_frame  = 1'b1;
      cur_idx   = tbl_idx;
      cur_n     = 0;
      cur_bytes = '0;
      ack_pend  = 1'b0;
      in_ack    = 1'b0;
    end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
      if (in_frame) obs_q.push_back({cur_idx, 8'(cur_n), cur_bytes});
      in_frame = 1'b0;
    end else if (!prev_scl && scl_l) begin
      if (bitcnt < 8) begin
        shreg = {shreg[6:0], sda_l};
        bitcnt++;
        if (bitcnt == 8) ack_pend = 1'b1;
      end else begin
        if (cur_n < 3) cur_bytes[23 - 8 * cur_n -: 8] = shreg;
        cur_n++;
        bitcnt = 0;
      end
    end else if (prev_scl && !scl_l) begin
      if (ack_pend) begin
        ack_pend = 1'b0;
        in_ack   = 1'b1;
        slv_sda  = (att >= 0 && att < 16) ? (plan[att] != cur_n) : 1'b1;
      end else if (in_ack) begin
        in_ack  = 1'b0;
        slv_sda = 1'b0;
      end
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  task automatic clear_mon();
    obs_q.delete();
    att = -1; rel_cnt = 0; bitcnt = 0; hold_cnt = 0;
    in_frame = 0; ack_pend = 0; in_ack = 0; str_arm = 0;
    slv_scl = 1'b0; slv_sda = 1'b0;
    prev_scl = 1'b1; prev_sda = 1'b1; prev_scl_oe = 1'b0;
  endtask

  // Reference model: walk the table attempt by attempt following the retry rules.
  logic [39:0] exp_q [$];
  bit          exp_done, exp_err;
  int          exp_eidx, exp_clk;

  task automatic model();
    int idx, r, a, nb, n;
    logic [23:0] full, mask;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_eidx = 0; exp_clk = 2;
    idx = 0; r = 0; a = 0;
    for (int guard = 0; guard < 16; guard++) begin
      nb   = plan[a];
      n    = (nb < 3) ? nb + 1 : 3;
      full = {7'h76, 1'b0, tbl[idx]};
      mask = 24'hFFFFFF << (8 * (3 - n));
      exp_q.push_back({8'(idx), 8'(n), full & mask});
      // START + 9 clocks per byte sent + STOP + GAP, 4 quarters of DIV each.
      exp_clk += (nb < 3) ? (3 + 9 * n) * 4 * DIV : 120 * DIV;
      a++;
      if (nb < 3) begin
        if (r < RETR) r++;
        else begin
          exp_err = 1; exp_eidx = idx;
          break;
        end
      end else if (idx == NREG - 1) begin
        exp_done = 1;
        break;
      end else begin
        idx++; r = 0;
      end
    end
  endtask

  task automatic launch_start(input string name, output int launch);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    launch = cyc;
    check({name, ".launch_busy"}, busy, 1'b1);
    check({name, ".launch_done"}, done, 1'b0);
    check({name, ".launch_idx"}, tbl_idx, 8'd0);
  endtask

  // Wait for busy to drop (bounded), then score the run against the model.
  task automatic finish_run(input string name, input int launch, input int extra,
                            input int mid, output int clocks);
    int fin;
    fin = -1;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      start = (mid > 0 && cyc - launch == mid);
      if (!busy) begin
        fin = cyc;
        break;
      end
    end
    start = 1'b0;
    clocks = (fin < 0) ? -1 : fin - launch + 1;
    model();
    check({name, ".finished"}, (fin >= 0), 1'b1);
    check({name, ".records"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s.rec%0d", name, i), obs_q[i], exp_q[i]);
    check({name, ".done"}, done, exp_done);
    check({name, ".error"}, error, exp_err);
    if (exp_err) check({name, ".err_idx"}, err_idx, exp_eidx);
    check({name, ".clocks"}, clocks, exp_clk + extra);
  endtask

  task automatic prep();
    @(posedge clk);
    #1;
    clear_mon();
  endtask

  initial begin
    int launch, clocks, mid;
    bit ok;
    rst_n = 1'b0;
    start = 1'b0;
    plan  = '{default: 3};
    tbl[0] = 16'h49C0;
    tbl[1] = 16'h2109;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst.scl_oe", scl_oe, 1'b0);
    check("rst.sda_oe", sda_oe, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.error", error, 1'b0);
    check("rst.err_idx", err_idx, 8'd0);
    check("rst.tbl_idx", tbl_idx, 8'd0);

    // Auto start after reset, both entries ACKed.
    rst_n = 1'b1;
    @(negedge clk);
    launch = cyc;
    check("auto.busy", busy, 1'b1);
    finish_run("auto", launch, 0, 0, clocks);
    check("auto.clock482", clocks, 482);

    // Address byte of entry 0 NACKed on every attempt.
    prep();
    plan = '{default: 3};
    plan[0] = 0; plan[1] = 0; plan[2] = 0;
    launch_start("nack_addr", launch);
    finish_run("nack_addr", launch, 0, 0, clocks);

    // Data byte of entry 1 NACKed once.
    prep();
    plan = '{default: 3};
    plan[1] = 2;
    launch_start("nack_data", launch);
    finish_run("nack_data", launch, 0, 0, clocks);

    // 37-clock SCL stretch in bit 3 of entry 0.
    prep();
    plan = '{default: 3};
    str_arm = 1; str_att = 0; str_rel = 4; str_len = 37;
    launch_start("stretch", launch);
    finish_run("stretch", launch, 37, 0, clocks);

    // start pulsed mid-sequence is ignored.
    prep();
    launch_start("mid_start", launch);
    finish_run("mid_start", launch, 0, 150, clocks);

    // Randomized tables and NACK patterns.
    for (int it = 0; it < 6; it++) begin
      prep();
      tbl[0] = 16'($urandom);
      tbl[1] = 16'($urandom);
      for (int a = 0; a < 16; a++)
        plan[a] = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 2));
      mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 200)) : 0;
      launch_start($sformatf("rand%0d", it), launch);
      finish_run($sformatf("rand%0d", it), launch, 0, mid, clocks);
    end

    // Reset asserted mid-bit of entry 1, then auto restart from entry 0.
    prep();
    plan = '{default: 3};
    tbl[0] = 16'h49C0;
    tbl[1] = 16'h2109;
    launch_start("rst_mid", launch);
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (att == 1) begin
        ok = 1;
        break;
      end
    end
    repeat (20) @(negedge clk);
    for (int k = 0; k < 100 && ok; k++) begin
      if (scl_oe) break;
      @(negedge clk);
    end
    check("rst_mid.reached_entry1", ok, 1'b1);
    check("rst_mid.idx_before", tbl_idx, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid.scl_oe", scl_oe, 1'b0);
    check("rst_mid.sda_oe", sda_oe, 1'b0);
    check("rst_mid.busy", busy, 1'b0);
    check("rst_mid.done", done, 1'b0);
    check("rst_mid.error", error, 1'b0);
    check("rst_mid.err_idx", err_idx, 8'd0);
    check("rst_mid.tbl_idx", tbl_idx, 8'd0);
    repeat (3) @(negedge clk);
    prep();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch = cyc;
    finish_run("rst_restart", launch, 0, 0, clocks);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
